mips_state_sequencer: RTL and testbench
=======================================

MIPS_STATE_SEQUENCER -- requirements
Module: mips_state_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the clock port is clk and the reset port is reset.
REQ-002 The block SHALL have these ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- opcode  input  6  instruction bits [31:26] from the instruction register; valid from DECODE onward
- waitrequest  input  1  memory-bus stall; high means the current access has not completed
- halt_req  input  1  from datapath: next PC == 0x00000000
- state  output  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALTED=5
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  load instruction register
- pc_write  output  1  update PC
- reg_write  output  1  register file write enable
- imdt_sel  output  1  1 = zero-extended immediate, 0 = sign-extended immediate
- active  output  1  CPU running
- stall_count  output  16  waitrequest stall cycles (see Configuration)

Function
REQ-003 The state machine SHALL move at most one state per rising clk edge; all strobes SHALL be decoded combinationally from state, opcode and waitrequest.
REQ-004 FETCH SHALL assert mem_read=1.
- waitrequest=1: stay in FETCH, ir_write=0.
- waitrequest=0: ir_write=1 for that cycle, next state DECODE.
REQ-005 DECODE SHALL assert no strobes and go to EXEC unconditionally.
REQ-006 EXEC SHALL assert no strobes.
- Next state MEM for loads (opcode 0x20–0x26) and stores (0x28, 0x29, 0x2B).
- Next state WB for every other opcode.
REQ-007 MEM SHALL assert mem_read=1 for loads and mem_write=1 for stores.
- waitrequest=1: stay in MEM.
- waitrequest=0: next state WB.
REQ-008 WB SHALL assert pc_write=1 for exactly one cycle.
REQ-009 In WB, reg_write SHALL be 1, except it SHALL be 0 for:
- opcodes 0x01, 0x02, 0x04–0x07;
- stores.
REQ-010 From WB, the next state SHALL be HALTED if halt_req=1, otherwise FETCH; halt_req SHALL be ignored in all other states.
REQ-011 HALTED SHALL be absorbing until reset, with active=0 and all strobes 0; active SHALL be 1 in every other state.
REQ-012 imdt_sel SHALL be 1 exactly when opcode is 0x0C, 0x0D or 0x0E (ANDI/ORI/XORI), and 0 otherwise, independent of state.
REQ-013 mem_read and mem_write SHALL never both be 1; waitrequest SHALL be ignored outside FETCH and MEM.
REQ-014 Latency SHALL be:
- non-memory instruction with zero stalls: 4 cycles (FETCH, DECODE, EXEC, WB);
- load/store with zero stalls: 5 cycles;
- each waitrequest cycle adds 1 cycle.

Reset
REQ-015 Asserting reset SHALL immediately, without waiting for clk, force state=FETCH and active=1, and force stall_count=0 when the counter is compiled in (REQ-019).
REQ-016 While reset is high, mem_read, mem_write, ir_write, pc_write and reg_write SHALL be 0.
REQ-017 Reset asserted mid-operation (any state, including during a MEM stall or in HALTED) SHALL abandon the instruction; the first cycle after reset deasserts SHALL be FETCH with mem_read=1.

Configuration
REQ-018 Macro STALL_COUNTER_EN SHALL control the stall counter.
REQ-019 With STALL_COUNTER_EN defined:
- stall_count SHALL increment by 1 on each rising clk edge where (state is FETCH or MEM) and waitrequest=1;
- it SHALL saturate at 0xFFFF;
- it SHALL hold its value in HALTED.
REQ-020 Without STALL_COUNTER_EN, stall_count SHALL be constant 0 and no counter register SHALL be built.

Verification
REQ-021 The bench SHALL cover:
- ADDIU (0x09), waitrequest=0, halt_req=0 -> states 0,1,2,4,0; pc_write=1 and reg_write=1 only in the WB cycle; imdt_sel=0.
- ORI (0x0D) -> imdt_sel=1 in every state; LW (0x23) with waitrequest=1 for 3 MEM cycles -> MEM held 3 extra cycles, mem_read=1 throughout, WB reg_write=1; stall_count=3 with STALL_COUNTER_EN defined, 0 without.
- SW (0x2B), waitrequest=0 -> mem_write=1, mem_read=0 in MEM; WB reg_write=0.
- JR with halt_req=1 in WB -> state=5, active=0 next cycle; stays in HALTED for 10 cycles regardless of inputs.
- reset pulsed mid-MEM with waitrequest=1 -> state=0 and strobes 0 immediately; with STALL_COUNTER_EN defined, stall_count=0; FETCH with mem_read=1 after release.
- STALL_COUNTER_EN defined, waitrequest held 1 in FETCH for 70000 cycles -> stall_count saturates at 0xFFFF.

Source files
------------

// File: rtl/mips_state_sequencer.sv
// Multicycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALTED with combinational strobes.
// Optional waitrequest stall counter is compiled in when STALL_COUNTER_EN is defined.
module mips_state_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        waitrequest,
    input  logic        halt_req,
    output logic [2:0]  state,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        imdt_sel,
    output logic        active,
    output logic [15:0] stall_count
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALTED = 3'd5
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic is_load;
    logic is_store;
    logic no_reg_write;

    assign is_load      = (opcode >= 6'h20) && (opcode <= 6'h26);
    assign is_store     = (opcode == 6'h28) || (opcode == 6'h29) || (opcode == 6'h2B);
    // Branches, REGIMM and J never write the register file; stores are handled separately.
    assign no_reg_write = (opcode == 6'h01) || (opcode == 6'h02) ||
                          ((opcode >= 6'h04) && (opcode <= 6'h07));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        case (state_reg)
            FETCH: begin
                mem_read = 1'b1;
                if (!waitrequest) begin
                    ir_write   = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: state_next = EXEC;
            EXEC:   state_next = (is_load || is_store) ? MEM : WB;
            MEM: begin
                mem_read  = is_load;
                mem_write = is_store;
                if (!waitrequest) begin
                    state_next = WB;
                end
            end
            WB: begin
                pc_write   = 1'b1;
                reg_write  = !(no_reg_write || is_store);
                state_next = halt_req ? HALTED : FETCH;
            end
            HALTED:  state_next = HALTED;
            default: state_next = FETCH;
        endcase
        // Reset forces FETCH asynchronously, so its read strobe must be masked here.
        if (reset) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign state    = state_reg;
    assign active   = (state_reg != HALTED);
    assign imdt_sel = (opcode == 6'h0C) || (opcode == 6'h0D) || (opcode == 6'h0E);

`ifdef STALL_COUNTER_EN
    logic [15:0] stall_count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_reg <= 16'd0;
        end else if (((state_reg == FETCH) || (state_reg == MEM)) && waitrequest &&
                     (stall_count_reg != 16'hFFFF)) begin
            stall_count_reg <= stall_count_reg + 16'd1;
        end
    end

    assign stall_count = stall_count_reg;
`else
    assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_mips_state_sequencer.sv
// Directed bench for mips_state_sequencer; expected stall counts follow STALL_COUNTER_EN.
module tb_mips_state_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic        waitrequest = 1'b0;
    logic        halt_req = 1'b0;
    logic [2:0]  state;
    logic        mem_read, mem_write, ir_write, pc_write, reg_write, imdt_sel, active;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    mips_state_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .waitrequest (waitrequest),
        .halt_req    (halt_req),
        .state       (state),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .imdt_sel    (imdt_sel),
        .active      (active),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_stalls(input int n);
`ifdef STALL_COUNTER_EN
        return 16'(n);
`else
        return 16'd0;
`endif
    endfunction

    // eo bit order: mem_read mem_write ir_write pc_write reg_write imdt_sel active
    task automatic cyc(input string tag, input logic [5:0] op, input logic wr, input logic hr,
                       input logic [2:0] es, input logic [6:0] eo);
        opcode      = op;
        waitrequest = wr;
        halt_req    = hr;
        #1;
        check({tag, ".state"}, 16'(state), 16'(es));
        check({tag, ".strobes"},
              {9'd0, mem_read, mem_write, ir_write, pc_write, reg_write, imdt_sel, active},
              {9'd0, eo});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, ".state"}, 16'(state), 16'd0);
        check({tag, ".strobes"},
              {9'd0, mem_read, mem_write, ir_write, pc_write, reg_write, active},
              {9'd0, 6'b000001});
        check({tag, ".stall"}, stall_count, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #2;
        opcode = 6'h23;
        waitrequest = 1'b1;
        do_reset("rst0");
        $display("txn reset checks=%0d", checks);

        // ADDIU
        cyc("addiu.f", 6'h09, 0, 0, 3'd0, 7'b1010001);
        cyc("addiu.d", 6'h09, 0, 0, 3'd1, 7'b0000001);
        cyc("addiu.e", 6'h09, 0, 0, 3'd2, 7'b0000001);
        cyc("addiu.w", 6'h09, 0, 0, 3'd4, 7'b0001101);
        $display("txn addiu checks=%0d", checks);

        // ORI
        cyc("ori.f", 6'h0D, 0, 0, 3'd0, 7'b1010011);
        cyc("ori.d", 6'h0D, 0, 0, 3'd1, 7'b0000011);
        cyc("ori.e", 6'h0D, 0, 0, 3'd2, 7'b0000011);
        cyc("ori.w", 6'h0D, 0, 0, 3'd4, 7'b0001111);
        $display("txn ori checks=%0d", checks);

        // LW with three MEM stalls
        cyc("lw.f", 6'h23, 0, 0, 3'd0, 7'b1010001);
        cyc("lw.d", 6'h23, 0, 0, 3'd1, 7'b0000001);
        cyc("lw.e", 6'h23, 0, 0, 3'd2, 7'b0000001);
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("lw.mstall%0d", i), 6'h23, 1, 0, 3'd3, 7'b1000001);
        end
        cyc("lw.m", 6'h23, 0, 0, 3'd3, 7'b1000001);
        check("lw.stall_count", stall_count, exp_stalls(3));
        cyc("lw.w", 6'h23, 0, 0, 3'd4, 7'b0001101);
        $display("txn lw checks=%0d", checks);

        // SW with one FETCH stall
        cyc("sw.fstall", 6'h2B, 1, 0, 3'd0, 7'b1000001);
        cyc("sw.f", 6'h2B, 0, 0, 3'd0, 7'b1010001);
        cyc("sw.d", 6'h2B, 0, 0, 3'd1, 7'b0000001);
        cyc("sw.e", 6'h2B, 0, 0, 3'd2, 7'b0000001);
        cyc("sw.m", 6'h2B, 0, 0, 3'd3, 7'b0100001);
        cyc("sw.w", 6'h2B, 0, 0, 3'd4, 7'b0001001);
        check("sw.stall_count", stall_count, exp_stalls(4));
        $display("txn sw checks=%0d", checks);

        // BEQ: no register write in WB
        cyc("beq.f", 6'h04, 0, 0, 3'd0, 7'b1010001);
        cyc("beq.d", 6'h04, 0, 0, 3'd1, 7'b0000001);
        cyc("beq.e", 6'h04, 0, 0, 3'd2, 7'b0000001);
        cyc("beq.w", 6'h04, 0, 0, 3'd4, 7'b0001001);
        $display("txn beq checks=%0d", checks);

        // JR with halt_req held high; only WB may act on it
        cyc("jr.f", 6'h00, 0, 1, 3'd0, 7'b1010001);
        cyc("jr.d", 6'h00, 0, 1, 3'd1, 7'b0000001);
        cyc("jr.e", 6'h00, 0, 1, 3'd2, 7'b0000001);
        cyc("jr.w", 6'h00, 0, 1, 3'd4, 7'b0001101);
        for (int i = 0; i < 10; i++) begin
            logic [5:0] op;
            op = i[0] ? 6'h0C : 6'h23;
            cyc($sformatf("halted%0d", i), op, 1, i[1], 3'd5, {5'b00000, i[0], 1'b0});
        end
        check("halted.stall_count", stall_count, exp_stalls(4));
        $display("txn jr_halt checks=%0d", checks);

        opcode = 6'h23;
        do_reset("rst_halted");
        $display("txn reset_from_halted checks=%0d", checks);

        // Reset pulsed while stalled in MEM
        cyc("lw2.f", 6'h23, 0, 0, 3'd0, 7'b1010001);
        cyc("lw2.d", 6'h23, 0, 0, 3'd1, 7'b0000001);
        cyc("lw2.e", 6'h23, 0, 0, 3'd2, 7'b0000001);
        cyc("lw2.mstall", 6'h23, 1, 0, 3'd3, 7'b1000001);
        waitrequest = 1'b1;
        #2;
        do_reset("rst_mem");
        cyc("post_rst.f", 6'h23, 0, 0, 3'd0, 7'b1010001);
        $display("txn reset_mid_mem checks=%0d", checks);

`ifdef STALL_COUNTER_EN
        // Long FETCH stall saturates the counter
        opcode = 6'h00;
        waitrequest = 1'b1;
        #1;
        repeat (70000) @(posedge clk);
        #1;
        check("sat.stall_count", stall_count, 16'hFFFF);
        check("sat.state", 16'(state), 16'd0);
        check("sat.strobes", {14'd0, mem_read, ir_write}, 16'b10);
        $display("txn saturation checks=%0d", checks);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
